fold_out_collector: RTL and testbench

- Receiving end of the folded 5-tap FIR datapath.
- The folded filter produces one valid 9-bit signed result every FOLD clocks, on a fixed phase of its schedule. This block tracks that schedule with a phase counter, discards the pipeline warm-up results and captures each valid result.
- Captured results go into a small FIFO and are presented downstream on a valid/ready stream.

---
 rtl/fold_pkg.sv | 14 +
 rtl/fold_sync_fifo.sv | 50 +++++
 rtl/fold_out_collector.sv | 136 +++++++++++++
 tb/tb_fold_out_collector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fold_pkg.sv
// rtl/fold_pkg.sv - shared state encoding and default constants for the fold output collector
package fold_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int FOLD_DEF = 5;
  localparam int W_DEF    = 9;
  localparam int DROP_W   = 8;

endpackage

// File: rtl/fold_sync_fifo.sv
// rtl/fold_sync_fifo.sv - synchronous FIFO with registered head, flush and full/empty flags
module fold_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_pop;
  logic         w_push;

  // Extra pointer MSB tells a full FIFO apart from an empty one.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & ~i_flush & (~o_full | w_pop);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fold_out_collector.sv
// rtl/fold_out_collector.sv - tracks the folded FIR schedule, drops warm-up results, queues the rest
// Optional SAT_OUT_EN: clamp captures to 8-bit signed range and expose sticky sat_flag.
module fold_out_collector
  import fold_pkg::*;
#(
  parameter int FOLD      = FOLD_DEF,
  parameter int CAP_PHASE = 4,
  parameter int WARMUP    = 2,
  parameter int DEPTH     = 4,
  parameter int W         = W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic [W-1:0]      fir_out,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
`ifdef SAT_OUT_EN
  output logic              sat_flag,
`endif
  output logic [1:0]        state
);

  localparam int PW  = $clog2(FOLD);
  localparam int WCW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  state_t              r_state;
  state_t              w_state_nx;
  logic [PW-1:0]       r_phase;
  logic [PW-1:0]       w_phase_nx;
  logic [WCW-1:0]      r_warm_cnt;
  logic [WCW-1:0]      w_warm_nx;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic                w_cap;
  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_drop;
  logic                w_full;
  logic                w_empty;
  logic [W-1:0]        w_cap_data;

  // The start cycle is phase 0 of the new run, so it never captures.
  assign w_cap   = (r_state != IDLE) && (r_phase == PW'(CAP_PHASE)) && !start;
  assign w_flush = flush & ~start;
  assign w_pop   = ~w_empty & out_ready;
  assign w_drop  = w_push & ~w_flush & w_full & ~w_pop;

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_warm_nx  = r_warm_cnt;
    w_push     = 1'b0;
    if (start) begin
      w_state_nx = (WARMUP == 0) ? RUN : WARM;
      w_phase_nx = PW'(1);
      w_warm_nx  = '0;
    end else begin
      if (r_state != IDLE)
        w_phase_nx = (r_phase == PW'(FOLD - 1)) ? '0 : r_phase + 1'b1;
      case (r_state)
        WARM: if (w_cap) begin
          w_warm_nx = r_warm_cnt + 1'b1;
          if (int'(r_warm_cnt) + 1 >= WARMUP) w_state_nx = RUN;
        end
        RUN:     w_push = w_cap;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_phase    <= '0;
      r_warm_cnt <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_phase    <= w_phase_nx;
      r_warm_cnt <= w_warm_nx;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

`ifdef SAT_OUT_EN
  localparam logic signed [W-1:0] SAT_MAX = W'(127);
  localparam logic signed [W-1:0] SAT_MIN = W'(-128);

  logic w_sat_hi;
  logic w_sat_lo;
  logic r_sat_flag;

  assign w_sat_hi   = $signed(fir_out) > SAT_MAX;
  assign w_sat_lo   = $signed(fir_out) < SAT_MIN;
  assign w_cap_data = w_sat_hi ? SAT_MAX : (w_sat_lo ? SAT_MIN : fir_out);
  assign sat_flag   = r_sat_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_sat_flag <= 1'b0;
    else if (w_push && (w_sat_hi || w_sat_lo)) r_sat_flag <= 1'b1;
  end
`else
  assign w_cap_data = fir_out;
`endif

  fold_sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_cap_data),
    .o_head  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = ~w_empty;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;
  assign state     = r_state;

endmodule

// File: tb/tb_fold_out_collector.sv
// tb/tb_fold_out_collector.sv - scoreboard bench for fold_out_collector
module tb_fold_out_collector;
  import fold_pkg::*;

  localparam int FOLD = 5, CAP_PHASE = 4, WARMUP = 2, DEPTH = 4, W = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;
  logic [W-1:0]      fir_out = '0;
  logic [W-1:0]      out_data;
  logic              out_valid;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic [1:0]        state;
`ifdef SAT_OUT_EN
  logic              sat_flag;
`endif

  always #5 clk = ~clk;

  fold_out_collector #(
    .FOLD(FOLD), .CAP_PHASE(CAP_PHASE), .WARMUP(WARMUP), .DEPTH(DEPTH), .W(W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .flush     (flush),
    .fir_out   (fir_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
`ifdef SAT_OUT_EN
    .sat_flag  (sat_flag),
`endif
    .state     (state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: m_* is the state after the last edge, x_* the prediction for the next one.
  bit m_run = 0, x_run = 0, m_ovf = 0, x_ovf = 0, m_sat = 0, x_sat = 0;
  int m_cyc = 0, x_cyc = 0, m_ncap = 0, x_ncap = 0;
  int m_occ = 0, x_occ = 0, m_drop = 0, x_drop = 0;
  logic [W-1:0] exp_q[$];
  bit mon_en = 0;
  int gcyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sval(input logic [W-1:0] d);
    return int'($signed(d));
  endfunction

  function automatic bit is_sat(input logic [W-1:0] d);
`ifdef SAT_OUT_EN
    return (sval(d) > 127) || (sval(d) < -128);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [W-1:0] expv(input logic [W-1:0] d);
    int v;
    v = sval(d);
`ifdef SAT_OUT_EN
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
`endif
    return W'(v);
  endfunction

  function automatic int exp_state();
    if (!m_run) return 0;
    return (m_ncap < WARMUP) ? 1 : 2;
  endfunction

  function automatic bit next_is_cap();
    return x_run && (x_cyc % FOLD == CAP_PHASE);
  endfunction

  task automatic step(input bit s, input bit f, input bit r, input logic [W-1:0] d);
    bit pop, cap, push;
    @(posedge clk);
    #2;
    m_run = x_run; m_cyc = x_cyc; m_ncap = x_ncap; m_occ = x_occ;
    m_drop = x_drop; m_ovf = x_ovf; m_sat = x_sat;
    mon_en = 1;
    gcyc++;
    if (f) r = 1'b0;
    start = s; flush = f; out_ready = r; fir_out = d;
    pop  = (m_occ > 0) && r;
    cap  = m_run && !s && (m_cyc % FOLD == CAP_PHASE);
    push = cap && (m_ncap >= WARMUP);
    if (s) begin
      x_run = 1; x_cyc = 1; x_ncap = 0;
    end else if (m_run) begin
      x_cyc = m_cyc + 1; x_ncap = m_ncap + (cap ? 1 : 0);
    end
    x_occ = m_occ - (pop ? 1 : 0);
    if (push && is_sat(d)) x_sat = 1;
    if (f && !s) begin
      x_occ = 0;
      exp_q.delete();
    end else if (push) begin
      if (m_occ < DEPTH || pop) begin
        x_occ++;
        exp_q.push_back(expv(d));
      end else begin
        x_ovf = 1;
        if (x_drop < 255) x_drop++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", int'(out_valid), int'(m_occ > 0));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("state", int'(state), exp_state());
`ifdef SAT_OUT_EN
      chk("sat_flag", int'(sat_flag), int'(m_sat));
`endif
    end
  end

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_state", int'(state), 0);
    rst_n = 1'b1;

    // Idle cycles, then start with a ramp and downstream always ready.
    repeat (3) step(0, 0, 1, W'(gcyc));
    step(1, 0, 1, W'(gcyc));
    repeat (40) step(0, 0, 1, W'(gcyc));

    // Downstream stalls for six captures, then drains.
    repeat (30) step(0, 0, 0, W'(gcyc));
    repeat (25) step(0, 0, 1, W'(gcyc));

    // Fill, then pop only on capture cycles so full + pop + push coincide.
    repeat (25) step(0, 0, 0, W'($urandom));
    repeat (20) step(0, 0, next_is_cap(), W'($urandom));

    // Restart mid-RUN on phase 2 with FIFO contents held.
    repeat (12) step(0, 0, 0, W'($urandom));
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (x_run && x_ncap >= WARMUP && (x_cyc % FOLD == 2)) found = 1;
      else step(0, 0, 0, W'($urandom));
    end
    chk("find_phase2", int'(found), 1);
    step(1, 0, 0, W'($urandom));
    repeat (20) step(0, 0, 0, W'($urandom));
    repeat (20) step(0, 0, 1, W'($urandom));

    // Flush on a capture cycle with entries queued.
    repeat (10) step(0, 0, 0, W'($urandom));
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (next_is_cap()) found = 1;
      else step(0, 0, 0, W'($urandom));
    end
    chk("find_capture", int'(found), 1);
    step(0, 1, 0, W'($urandom));
    repeat (10) step(0, 0, 1, W'($urandom));

`ifdef SAT_OUT_EN
    for (int i = 0; i < 20; i++) step(0, 0, 1, (i % 2 == 0) ? W'(200) : W'(-200));
`endif

    // Random mix of starts, flushes and backpressure.
    repeat (400) step($urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 1) == 1, W'($urandom));

    // Long stall drives drop_cnt into saturation.
    repeat (1350) step(0, 0, 0, W'($urandom));
    repeat (30) step(0, 0, 1, W'($urandom));
    chk("drop_saturated", int'(drop_cnt), 255);

    // Reset mid-run loses everything.
    repeat (20) step(0, 0, 0, W'($urandom));
    @(posedge clk);
    #2;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    chk("midrst_overflow", int'(overflow), 0);
    chk("midrst_drop_cnt", int'(drop_cnt), 0);
    chk("midrst_state", int'(state), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
